// File: rtl/fixed_extractor_if.sv
// Handshake bundle for fixed_extractor: wide fixed-point input stream and
// narrow integer output stream, each with valid/ready.
interface fixed_extractor_if #(
  parameter int N = 61,
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // Block side: consumes the input stream, produces the output stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: produces input samples, consumes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fixed_extractor.sv
// fixed_extractor: rounds a wide signed fixed-point sample (F fractional bits)
// to a W-bit signed integer with saturation. Two-stage elastic pipeline:
// stage 1 holds the rounded (half-added) value, stage 2 holds the clamped
// result and drives the output directly. A sticky flag and a saturating
// counter record clamp events at the moment a sample enters stage 2.
module fixed_extractor #(
  parameter int N  = 61,
  parameter int F  = 19,
  parameter int W  = 12,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  fixed_extractor_if.slave  bus,
  input  logic              clr,
  output logic              sat,
  output logic [CW-1:0]     sat_cnt
);

  // Half an LSB of the output, at the widened N+1 precision.
  localparam logic signed [N:0] HALF   = (N+1)'(1) << (F-1);
  // Clamp limits compared at full precision, and their W-bit encodings.
  localparam logic signed [N:0] SAT_HI = (N+1)'((1 << (W-1)) - 1);
  localparam logic signed [N:0] SAT_LO = -SAT_HI - (N+1)'(1);
  localparam logic [W-1:0]      OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]      OUT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]     CNT_MAX = {CW{1'b1}};

  logic                init_q, init_d;
  logic                s1_valid_q, s1_valid_d;
  logic signed [N:0]   s1_q, s1_d;
  logic                s2_valid_q, s2_valid_d;
  logic [W-1:0]        s2_data_q, s2_data_d;
  logic                sat_q, sat_d;
  logic [CW-1:0]       sat_cnt_q, sat_cnt_d;

  logic                adv2;
  logic                in_ready;
  logic                in_fire;
  logic                out_fire;
  logic                hit;
  logic                sat_hit;
  logic signed [N:0]   r;
  logic signed [N:0]   q;
  logic [W-1:0]        clamped;

  // Datapath: add half (one extra bit so it never overflows), then floor
  // via arithmetic shift and clamp to the W-bit signed range.
  always_comb begin
    r       = $signed({bus.in_data[N-1], bus.in_data}) + HALF;
    q       = s1_q >>> F;
    hit     = 1'b0;
    clamped = q[W-1:0];
    if (q > SAT_HI) begin
      clamped = OUT_MAX;
      hit     = 1'b1;
    end else if (q < SAT_LO) begin
      clamped = OUT_MIN;
      hit     = 1'b1;
    end
  end

  // Flow control: stage 1 moves into stage 2 whenever stage 2 is empty or
  // draining this cycle; input is accepted whenever stage 1 will be free.
  always_comb begin
    adv2     = s1_valid_q && (!s2_valid_q || bus.out_ready);
    in_ready = init_q && (!s1_valid_q || adv2);
    in_fire  = bus.in_valid && in_ready;
    out_fire = s2_valid_q && bus.out_ready;
    sat_hit  = adv2 && hit;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign sat           = sat_q;
  assign sat_cnt       = sat_cnt_q;

  // Next-state for both pipeline stages and the saturation statistics.
  always_comb begin
    init_d     = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    sat_d      = sat_q;
    sat_cnt_d  = sat_cnt_q;

    if (in_fire) begin
      s1_d       = r;
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      s2_data_d  = clamped;
      s2_valid_d = 1'b1;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    // A new event in the same cycle as clr wins: count restarts at one.
    if (sat_hit) begin
      sat_d = 1'b1;
      if (clr) begin
        sat_cnt_d = CW'(1);
      end else if (sat_cnt_q != CNT_MAX) begin
        sat_cnt_d = sat_cnt_q + CW'(1);
      end
    end else if (clr) begin
      sat_d     = 1'b0;
      sat_cnt_d = '0;
    end
  end

  // State registers; reset discards any samples in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      init_q     <= init_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      sat_q      <= sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

endmodule
